bank_rsp_return_buf: RTL and testbench
======================================

BANK_RSP_RETURN_BUF -- requirements
Module: bank_rsp_return_buf

Interface
REQ-001 Parameter CHANNEL_NUM, default 3, number of memory channels.
REQ-002 Parameter FIFO_DEPTH, default 8, per-channel buffer entries; equals the per-channel credit reset value.
REQ-003 Parameter DATA_WIDTH, default 64, response data width.
REQ-004 Parameter TAG_WIDTH, default 8, issue-queue entry pointer carried with each response.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 ch_rsp_valid  input  CHANNEL_NUM  per-channel read-response beat valid; no ready, because space is guaranteed by credit.
REQ-008 ch_rsp_data  input  CHANNEL_NUM*DATA_WIDTH  packed per-channel data; channel c occupies slice c.
REQ-009 ch_rsp_tag  input  CHANNEL_NUM*TAG_WIDTH  packed per-channel issue-queue pointer.
REQ-010 rsp_valid  output  1  merged response to bank valid.
REQ-011 rsp_ready  input  1  bank accepts response.
REQ-012 rsp_data / rsp_tag / rsp_ch_id  output  DATA_WIDTH / TAG_WIDTH / 2  selected response payload and source channel.
REQ-013 channels_credit_release  output  CHANNEL_NUM  one-cycle pulse per freed slot; drives the credit manager release input.
REQ-014 overflow_err  output  1  sticky overflow flag; see Configuration.

Function
REQ-015 Each channel SHALL own one FIFO of FIFO_DEPTH entries {data, tag}, with read/write pointers of clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH and a count of clog2(FIFO_DEPTH)+1 bits.
REQ-016 A beat with ch_rsp_valid[c]=1 in cycle N SHALL be written to FIFO c and SHALL be eligible for output in cycle N+1, never in cycle N.
REQ-017 The arbiter SHALL grant among non-empty FIFOs round-robin, starting at rr_ptr and searching upward with wrap; rr_ptr SHALL advance to (granted+1) mod CHANNEL_NUM only on a handshake (rsp_valid & rsp_ready).
REQ-018 rsp_valid SHALL be 1 when any FIFO is non-empty; payload SHALL be the head of the granted FIFO.
REQ-019 While rsp_valid=1 and rsp_ready=0, the grant SHALL be locked, and rsp_data, rsp_tag and rsp_ch_id SHALL be held stable even if other FIFOs become non-empty.
REQ-020 On a handshake the granted FIFO SHALL pop, and channels_credit_release[granted] SHALL pulse high in that same cycle; all other release bits SHALL be 0.
REQ-021 Push and pop on the same FIFO in the same cycle SHALL both take effect with count unchanged, including when the FIFO is full (pop frees the slot first).
REQ-022 A push to a full FIFO without a simultaneous pop is an overflow: the beat SHALL be dropped, and pointers and count SHALL be unchanged.
REQ-023 At most one release bit SHALL be set per cycle.

Reset
REQ-024 While rst_n=0, all FIFO pointers/counts, rr_ptr, the grant lock and overflow_err SHALL be 0.
REQ-025 While rst_n=0, rsp_valid=0 and channels_credit_release=0.
REQ-026 FIFO data storage SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered beats without emitting any release pulse.

Configuration
REQ-028 With macro BANK_RSP_OVERFLOW_CHK_EN defined, overflow_err SHALL set in the cycle after the first overflow and hold until reset.
REQ-029 Without BANK_RSP_OVERFLOW_CHK_EN, overflow_err SHALL be tied 0, and overflow SHALL still drop the beat.

Structure
REQ-030 The shared bank package SHALL hold CHANNEL_NUM, the credit depth constant (8), and the channel-id width (2).
REQ-031 The per-channel FIFO SHALL be a sub-module named bank_rsp_fifo, instantiated CHANNEL_NUM times in a generate loop; the arbiter and release logic SHALL stay in the top module.

Verification
REQ-032 Scenario: after reset, push ch1 {data=0xA5, tag=0x12}, rsp_ready=1 -> next cycle rsp_valid=1, rsp_tag=0x12, rsp_ch_id=1, release=3'b010 in the same cycle.
REQ-033 Scenario: push all 3 channels in one cycle, rsp_ready=1 -> grants ch0, ch1, ch2 in three consecutive cycles; release sequence 001, 010, 100.
REQ-034 Scenario: ch2 granted with rsp_ready=0 for 4 cycles while ch0 is pushed -> payload stays ch2, no release; on ready, ch2 pops, then ch0 is granted.
REQ-035 Scenario: fill ch0 with 8 beats, then push and pop in the same cycle -> count stays 8, no overflow_err; then a 9th push with no pop -> overflow_err=1 (macro on) or 0 (macro off), and the beat is dropped.
REQ-036 Scenario: assert rst_n=0 with 5 beats buffered -> rsp_valid=0 and release=0 immediately; after reset release no stale beat is emitted.

Source files
------------

// File: rtl/bank_rsp_return_buf_pkg.sv
// Purpose: constants shared by the bank response return path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: channel count, per-channel credit depth, channel-id width.
package bank_rsp_return_buf_pkg;

  localparam int BANK_CHANNEL_NUM  = 3;  // memory channels feeding one bank
  localparam int BANK_CREDIT_DEPTH = 8;  // credits per channel == buffer slots
  localparam int BANK_CH_ID_W      = 2;  // width of the source channel id

endpackage

// File: rtl/bank_rsp_return_buf_fifo.sv
// Purpose: per-channel response buffer holding {tag, data} beats.
// Latency: a beat pushed in cycle N is at the head in cycle N+1.
// Backpressure: none upstream (credit guarantees space); a push to a full
//               buffer without a same-cycle pop is dropped and flagged.
//
// Ports: clk, rst_n; push/push_data/push_tag write side; pop read side;
//        empty, head_data, head_tag show the oldest beat; overflow pulses on a
//        dropped push.
module bank_rsp_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  input  logic                  pop,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [TAG_WIDTH-1:0]  head_tag,
  output logic                  overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH+TAG_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;

  assign {head_tag, head_data} = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_tag, push_data};
  end

endmodule

// File: rtl/bank_rsp_return_buf.sv
// Purpose: buffer per-channel read responses and merge them round-robin to the bank.
// Latency: 1 cycle from ch_rsp_valid to earliest rsp_valid.
// Backpressure: rsp_ready low locks the grant and holds the payload; inputs
//               never stall (credit-based), freed slots return one credit pulse.
//
// Ports: clk, rst_n; ch_rsp_valid/ch_rsp_data/ch_rsp_tag per-channel inputs;
//        rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_ch_id merged output;
//        channels_credit_release one-hot credit return; overflow_err sticky.
// Option: define BANK_RSP_OVERFLOW_CHK_EN to enable the sticky overflow_err.
module bank_rsp_return_buf
  import bank_rsp_return_buf_pkg::*;
#(
  parameter int CHANNEL_NUM = BANK_CHANNEL_NUM,
  parameter int FIFO_DEPTH  = BANK_CREDIT_DEPTH,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHANNEL_NUM-1:0]            ch_rsp_valid,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] ch_rsp_data,
  input  logic [CHANNEL_NUM*TAG_WIDTH-1:0]  ch_rsp_tag,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  output logic [BANK_CH_ID_W-1:0]           rsp_ch_id,
  output logic [CHANNEL_NUM-1:0]            channels_credit_release,
  output logic                              overflow_err
);

  logic [CHANNEL_NUM-1:0]  fifo_empty;
  logic [CHANNEL_NUM-1:0]  fifo_pop;
  logic [CHANNEL_NUM-1:0]  fifo_ovf;
  logic [DATA_WIDTH-1:0]   head_data [CHANNEL_NUM];
  logic [TAG_WIDTH-1:0]    head_tag  [CHANNEL_NUM];

  logic [BANK_CH_ID_W-1:0] rr_ptr;
  logic [BANK_CH_ID_W-1:0] rr_grant;
  logic                    rr_found;
  logic [BANK_CH_ID_W-1:0] grant;
  logic [BANK_CH_ID_W-1:0] rr_next;
  logic                    lock_vld;
  logic [BANK_CH_ID_W-1:0] lock_ch;
  logic                    handshake;

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    bank_rsp_fifo #(
      .DEPTH      (FIFO_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ch_rsp_valid[c]),
      .push_data (ch_rsp_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .push_tag  (ch_rsp_tag[c*TAG_WIDTH +: TAG_WIDTH]),
      .pop       (fifo_pop[c]),
      .empty     (fifo_empty[c]),
      .head_data (head_data[c]),
      .head_tag  (head_tag[c]),
      .overflow  (fifo_ovf[c])
    );
  end

  // Round-robin search from rr_ptr upward with wrap: first the channels at or
  // above rr_ptr, then the ones below it.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (!rr_found && (c >= int'(rr_ptr)) && !fifo_empty[c]) begin
        rr_grant = BANK_CH_ID_W'(c);
        rr_found = 1'b1;
      end
    end
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (!rr_found && (c < int'(rr_ptr)) && !fifo_empty[c]) begin
        rr_grant = BANK_CH_ID_W'(c);
        rr_found = 1'b1;
      end
    end
  end

  // A stalled grant stays put so the payload cannot change under the bank.
  assign grant     = lock_vld ? lock_ch : rr_grant;
  assign rsp_valid = ~&fifo_empty;
  assign handshake = rsp_valid & rsp_ready;
  assign rsp_ch_id = grant;
  assign rr_next   = (grant == BANK_CH_ID_W'(CHANNEL_NUM - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    fifo_pop = '0;
    rsp_data = '0;
    rsp_tag  = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (grant == BANK_CH_ID_W'(c)) begin
        rsp_data    = head_data[c];
        rsp_tag     = head_tag[c];
        fifo_pop[c] = handshake;
      end
    end
  end

  // The slot freed by the pop is returned as a credit in the same cycle.
  assign channels_credit_release = fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else if (handshake) begin
      rr_ptr   <= rr_next;
      lock_vld <= 1'b0;
    end else if (rsp_valid) begin
      lock_vld <= 1'b1;
      lock_ch  <= grant;
    end
  end

`ifdef BANK_RSP_OVERFLOW_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow_err <= 1'b0;
    else if (|fifo_ovf) overflow_err <= 1'b1;
  end
`else
  // Overflowing beats are still dropped inside the buffers; only the flag is off.
  logic unused_ovf;
  assign unused_ovf   = |fifo_ovf;
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_bank_rsp_return_buf.sv
module tb_bank_rsp_return_buf;

  localparam int NCH   = 3;
  localparam int DEPTH = 8;
  localparam int DW    = 64;
  localparam int TW    = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    ch_rsp_valid;
  logic [NCH*DW-1:0] ch_rsp_data;
  logic [NCH*TW-1:0] ch_rsp_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [TW-1:0]     rsp_tag;
  logic [1:0]        rsp_ch_id;
  logic [NCH-1:0]    channels_credit_release;
  logic              overflow_err;

  bank_rsp_return_buf #(
    .CHANNEL_NUM (NCH),
    .FIFO_DEPTH  (DEPTH),
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ch_rsp_valid            (ch_rsp_valid),
    .ch_rsp_data             (ch_rsp_data),
    .ch_rsp_tag              (ch_rsp_tag),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_data                (rsp_data),
    .rsp_tag                 (rsp_tag),
    .rsp_ch_id               (rsp_ch_id),
    .channels_credit_release (channels_credit_release),
    .overflow_err            (overflow_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: per-channel queues of accepted beats plus the arbitration
  // state the bank observes (next channel to favour, stalled channel).
  beat_t     mq [NCH][$];
  int        m_rr;
  bit        m_lock;
  int        m_lock_ch;
  bit        m_ovf;
  int        g;
  bit        exp_vld;
  logic [NCH-1:0] exp_rel;
  beat_t     hb;
  beat_t     nb;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_release", channels_credit_release, 0);
      chk("reset_overflow_err", overflow_err, 0);
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_rr = 0; m_lock = 0; m_lock_ch = 0; m_ovf = 0;
    end else begin
      g = -1;
      if (m_lock) g = m_lock_ch;
      else begin
        for (int i = 0; i < NCH; i++) begin
          if (g < 0 && mq[(m_rr + i) % NCH].size() > 0) g = (m_rr + i) % NCH;
        end
      end
      exp_vld = (g >= 0);
      exp_rel = (exp_vld && rsp_ready) ? NCH'(1 << g) : '0;
      chk("rsp_valid", rsp_valid, exp_vld);
      chk("credit_release", channels_credit_release, exp_rel);
      chk("overflow_err", overflow_err, m_ovf);
      if (exp_vld) begin
        hb = mq[g][0];
        chk("rsp_ch_id", rsp_ch_id, g);
        chk("rsp_data", rsp_data, hb.d);
        chk("rsp_tag", rsp_tag, hb.t);
        if (rsp_ready) begin
          void'(mq[g].pop_front());
          m_rr   = (g + 1) % NCH;
          m_lock = 0;
        end else begin
          m_lock    = 1;
          m_lock_ch = g;
        end
      end
      // Pop is applied first, so a same-cycle push into a full queue fits.
      for (int c = 0; c < NCH; c++) begin
        if (ch_rsp_valid[c]) begin
          nb.d = ch_rsp_data[c*DW +: DW];
          nb.t = ch_rsp_tag[c*TW +: TW];
          if (mq[c].size() < DEPTH) mq[c].push_back(nb);
`ifdef BANK_RSP_OVERFLOW_CHK_EN
          else m_ovf = 1;
`endif
        end
      end
    end
  end

  task automatic step(input logic [NCH-1:0] v, input logic rdy);
    ch_rsp_valid = v;
    rsp_ready    = rdy;
    for (int c = 0; c < NCH; c++) begin
      ch_rsp_data[c*DW +: DW] = {$urandom, $urandom};
      ch_rsp_tag[c*TW +: TW]  = TW'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    ch_rsp_valid = '0;
    ch_rsp_data  = '0;
    ch_rsp_tag   = '0;
    rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step('0, 1'b1);

    // Single beat on ch1 with fixed payload.
    ch_rsp_valid = 3'b010;
    rsp_ready    = 1'b1;
    ch_rsp_data[1*DW +: DW] = 64'hA5;
    ch_rsp_tag[1*TW +: TW]  = 8'h12;
    @(posedge clk);
    #1;
    step('0, 1'b1);
    step('0, 1'b1);

    // All three channels at once, drained in round-robin order.
    step(3'b111, 1'b1);
    repeat (4) step('0, 1'b1);

    // Stall on ch2 while ch0 arrives; grant must not move.
    step(3'b100, 1'b0);
    step(3'b001, 1'b0);
    repeat (3) step('0, 1'b0);
    repeat (3) step('0, 1'b1);

    // Fill ch0, push+pop at full, then a push into full with no pop.
    repeat (DEPTH) step(3'b001, 1'b0);
    step(3'b001, 1'b1);
    step(3'b001, 1'b0);
    step('0, 1'b0);
    repeat (DEPTH + 2) step('0, 1'b1);

    // Reset with five beats buffered; nothing stale may come out afterwards.
    step(3'b111, 1'b0);
    step(3'b011, 1'b0);
    ch_rsp_valid = '0;
    rsp_ready    = 1'b1;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step('0, 1'b1);

    // Random traffic with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      step(NCH'($urandom_range(0, 7) & $urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    repeat (3 * DEPTH + 4) step('0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
